// File: rtl/auth_responder.sv
// auth_responder: USB Type-C Authentication request decoder and response builder
module auth_responder #(
  parameter int CHUNK_BYTES  = 32,
  parameter int CERT_LEN     = 512,
  parameter int CERT_AW      = 10,
  parameter int SIGN_TIMEOUT = 1000,
  localparam int PAYLOAD_W   = 8 * CHUNK_BYTES
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [31:0]          req_header,
  input  logic [PAYLOAD_W-1:0] req_payload,
  input  logic [3:0]           slot_mask,
  input  logic [255:0]         digest_in,
  output logic                 cert_rd_en,
  output logic [CERT_AW+1:0]   cert_addr,
  input  logic [7:0]           cert_rd_data,
  output logic                 sign_req,
  output logic [255:0]         sign_nonce,
  input  logic                 sign_done,
  input  logic [PAYLOAD_W-1:0] sign_data,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [31:0]          resp_header,
  output logic [PAYLOAD_W-1:0] resp_payload,
  output logic [15:0]          resp_len
);
  localparam int CW = $clog2(CHUNK_BYTES) + 1;
  localparam int TW = $clog2(SIGN_TIMEOUT + 1);
  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] DECODE    = 3'd1;
  localparam logic [2:0] CERT_RD   = 3'd2;
  localparam logic [2:0] CHAL_WAIT = 3'd3;
  localparam logic [2:0] SEND      = 3'd4;
  logic [2:0]    state;
  logic [7:0]    ver_q, type_q;
  logic [1:0]    slot_q;
  logic [15:0]   off_q, len_q;
  logic [CW-1:0] n_q, rd_cnt;
  logic [TW-1:0] timer;
  logic [15:0]   rem, lim, n_w;
  logic          is_dig, is_cert, is_chal, err_ver, err_req;
  logic [7:0]    slot8;
  // Requested chunk is clipped by the chunk size and by what is left of the chain.
  assign rem     = 16'(CERT_LEN) - off_q;
  assign lim     = (len_q < 16'(CHUNK_BYTES)) ? len_q : 16'(CHUNK_BYTES);
  assign n_w     = (lim < rem) ? lim : rem;
  assign is_dig  = type_q == 8'h81;
  assign is_cert = type_q == 8'h82;
  assign is_chal = type_q == 8'h83;
  assign slot8   = {6'd0, slot_q};
  assign err_ver = ver_q != 8'h01;
  assign err_req = !(is_dig || is_cert || is_chal) ||
                   ((is_cert || is_chal) && !slot_mask[slot_q]) ||
                   (is_cert && (len_q == 16'd0 || off_q >= 16'(CERT_LEN)));
  assign req_ready  = state == IDLE;
  assign cert_rd_en = (state == CERT_RD) && (rd_cnt != n_q);
  assign cert_addr  = cert_rd_en ? {slot_q, off_q[CERT_AW-1:0] + CERT_AW'(rd_cnt)} : '0;
  // Request/response sequencing; ROM bytes land one cycle after their read strobe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      ver_q        <= '0;
      type_q       <= '0;
      slot_q       <= '0;
      off_q        <= '0;
      len_q        <= '0;
      n_q          <= '0;
      rd_cnt       <= '0;
      timer        <= '0;
      sign_req     <= 1'b0;
      sign_nonce   <= '0;
      resp_valid   <= 1'b0;
      resp_header  <= '0;
      resp_payload <= '0;
      resp_len     <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          ver_q  <= req_header[7:0];
          type_q <= req_header[15:8];
          slot_q <= req_header[17:16];
          off_q  <= req_payload[15:0];
          len_q  <= req_payload[31:16];
          if (req_header[15:8] == 8'h83) sign_nonce <= req_payload[255:0];
          state  <= DECODE;
        end
        DECODE: begin
          rd_cnt <= '0;
          timer  <= TW'(1);
          resp_payload <= '0;
          if (err_ver || err_req) begin
            resp_header <= {8'h00, err_ver ? 8'h02 : 8'h01, 8'h7F, 8'h01};
            resp_len    <= '0;
            resp_valid  <= 1'b1;
            state       <= SEND;
          end else if (is_dig) begin
            resp_header         <= {4'd0, slot_mask, 8'h00, 8'h01, 8'h01};
            resp_payload[255:0] <= digest_in;
            resp_len            <= 16'd32;
            resp_valid          <= 1'b1;
            state               <= SEND;
          end else if (is_cert) begin
            n_q   <= n_w[CW-1:0];
            state <= CERT_RD;
          end else begin
            sign_req <= 1'b1;
            state    <= CHAL_WAIT;
          end
        end
        CERT_RD: begin
          if (rd_cnt != '0) resp_payload[8*(int'(rd_cnt)-1) +: 8] <= cert_rd_data;
          if (rd_cnt == n_q) begin
            resp_header <= {8'h00, slot8, 8'h02, 8'h01};
            resp_len    <= 16'(n_q);
            resp_valid  <= 1'b1;
            state       <= SEND;
          end else begin
            rd_cnt <= rd_cnt + 1'b1;
          end
        end
        CHAL_WAIT: begin
          sign_req <= 1'b0;
          timer    <= timer + 1'b1;
          if (sign_done) begin
            resp_header  <= {8'h00, slot8, 8'h03, 8'h01};
            resp_payload <= sign_data;
            resp_len     <= 16'(CHUNK_BYTES);
            resp_valid   <= 1'b1;
            state        <= SEND;
          end else if (timer == TW'(SIGN_TIMEOUT)) begin
            resp_header  <= 32'h0004_7F01;
            resp_payload <= '0;
            resp_len     <= '0;
            resp_valid   <= 1'b1;
            state        <= SEND;
          end
        end
        SEND: if (resp_ready) begin
          resp_valid <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
